// File: rtl/nor_gate_bank_if.sv
// Gate-bank bus: CHANNELS groups of N_IN NOR inputs plus the per-channel output and glitch flag.
// The master drives the inputs; the slave (the gate bank) returns the outputs.
interface nor_gate_bank_if #(
    parameter int CHANNELS = 1,
    parameter int N_IN     = 4
);
    logic [CHANNELS*N_IN-1:0] a;
    logic [CHANNELS-1:0]      y;
    logic [CHANNELS-1:0]      glitch;

    modport master (output a, input  y, input  glitch);
    modport slave  (input  a, output y, output glitch);
endinterface

// File: rtl/nor_gate_bank.sv
// Bank of independent N_IN-input NOR gates with a DELAY-cycle modelled propagation delay,
// either inertial (pulses shorter than DELAY filtered and flagged) or transport (pure delay).
module nor_gate_bank #(
    parameter int                  CHANNELS = 1,
    parameter int                  N_IN     = 4,
    parameter int                  DELAY    = 1,
    parameter int                  MODE     = 0,
    parameter logic [CHANNELS-1:0] IV       = '0
) (
    input  logic           SIM_CLK,
    input  logic           SIM_RST,
    nor_gate_bank_if.slave bus
);
    localparam int            CW       = $clog2(DELAY) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DELAY - 1);

    if (CHANNELS < 1) begin : g_bad_channels
        $error("nor_gate_bank: CHANNELS must be at least 1");
    end
    if (N_IN < 1 || N_IN > 16) begin : g_bad_n_in
        $error("nor_gate_bank: N_IN must be in 1..16");
    end
    if (DELAY < 1 || DELAY > 16) begin : g_bad_delay
        $error("nor_gate_bank: DELAY must be in 1..16");
    end
    if (MODE < 0 || MODE > 1) begin : g_bad_mode
        $error("nor_gate_bank: MODE must be 0 (inertial) or 1 (transport)");
    end

    logic [CHANNELS-1:0] r;
    logic [CHANNELS-1:0] s_p0 = IV;
    logic [CHANNELS-1:0] y_out;
    logic [CHANNELS-1:0] glitch_out;

    always_comb begin
        r = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            r[c] = ~|bus.a[c*N_IN +: N_IN];
        end
    end

    // Stage p0: negedge sample of the raw NOR; intentionally not reset.
    always_ff @(negedge SIM_CLK) begin
        s_p0 <= r;
    end

    // Stage p1: posedge delay model driven only by the negedge sample.
    if (MODE == 0) begin : g_inertial
        logic [CHANNELS-1:0] y_p1;
        logic [CHANNELS-1:0] glitch_p1;
        logic [CW-1:0]       cnt_p1 [CHANNELS];

        always_ff @(posedge SIM_CLK) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (!SIM_RST) begin
                    y_p1[c]      <= IV[c];
                    glitch_p1[c] <= 1'b0;
                    cnt_p1[c]    <= '0;
                end else if (s_p0[c] == y_p1[c]) begin
                    // A return to y cancels any pending change, even on the expiring cycle.
                    cnt_p1[c]    <= '0;
                    glitch_p1[c] <= (cnt_p1[c] != '0);
                end else if (cnt_p1[c] == CNT_LAST) begin
                    y_p1[c]      <= s_p0[c];
                    cnt_p1[c]    <= '0;
                    glitch_p1[c] <= 1'b0;
                end else begin
                    cnt_p1[c]    <= cnt_p1[c] + 1'b1;
                    glitch_p1[c] <= 1'b0;
                end
            end
        end

        assign y_out      = y_p1;
        assign glitch_out = glitch_p1;
    end else begin : g_transport
        logic [DELAY-1:0] dly_p1 [CHANNELS];

        always_ff @(posedge SIM_CLK) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (!SIM_RST) begin
                    dly_p1[c] <= {DELAY{IV[c]}};
                end else begin
                    for (int i = DELAY - 1; i > 0; i--) begin
                        dly_p1[c][i] <= dly_p1[c][i-1];
                    end
                    dly_p1[c][0] <= s_p0[c];
                end
            end
        end

        always_comb begin
            y_out = '0;
            for (int c = 0; c < CHANNELS; c++) begin
                y_out[c] = dly_p1[c][DELAY-1];
            end
        end

        assign glitch_out = '0;
    end

    assign bus.y      = y_out;
    assign bus.glitch = glitch_out;
endmodule

// File: tb/tb_nor_gate_bank.sv
// Bench for nor_gate_bank: five configurations driven together, checked every cycle
// against a sample-history model, plus hand-computed expectations for the key scenarios.
module tb_nor_gate_bank;
    localparam int NK = 5;
    localparam int P_CH   [NK] = '{2, 1, 1, 1, 4};
    localparam int P_N    [NK] = '{4, 4, 4, 4, 2};
    localparam int P_D    [NK] = '{1, 3, 3, 4, 2};
    localparam int P_MODE [NK] = '{0, 0, 1, 0, 0};
    localparam int P_IV   [NK] = '{1, 1, 1, 1, 10};

    logic       SIM_CLK;
    logic       SIM_RST;
    logic [7:0] a_drv [NK];
    logic [3:0] y_dut [NK];
    logic [3:0] g_dut [NK];

    int checks;
    int failures;

    nor_gate_bank_if #(.CHANNELS(2), .N_IN(4)) if0 ();
    nor_gate_bank_if #(.CHANNELS(1), .N_IN(4)) if1 ();
    nor_gate_bank_if #(.CHANNELS(1), .N_IN(4)) if2 ();
    nor_gate_bank_if #(.CHANNELS(1), .N_IN(4)) if3 ();
    nor_gate_bank_if #(.CHANNELS(4), .N_IN(2)) if4 ();

    nor_gate_bank #(.CHANNELS(2), .N_IN(4), .DELAY(1), .MODE(0), .IV(2'b01))
        u0 (.SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .bus(if0));
    nor_gate_bank #(.CHANNELS(1), .N_IN(4), .DELAY(3), .MODE(0), .IV(1'b1))
        u1 (.SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .bus(if1));
    nor_gate_bank #(.CHANNELS(1), .N_IN(4), .DELAY(3), .MODE(1), .IV(1'b1))
        u2 (.SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .bus(if2));
    nor_gate_bank #(.CHANNELS(1), .N_IN(4), .DELAY(4), .MODE(0), .IV(1'b1))
        u3 (.SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .bus(if3));
    nor_gate_bank #(.CHANNELS(4), .N_IN(2), .DELAY(2), .MODE(0), .IV(4'b1010))
        u4 (.SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .bus(if4));

    assign if0.a = a_drv[0];
    assign if1.a = a_drv[1][3:0];
    assign if2.a = a_drv[2][3:0];
    assign if3.a = a_drv[3][3:0];
    assign if4.a = a_drv[4];

    assign y_dut[0] = {2'b00, if0.y};
    assign y_dut[1] = {3'b000, if1.y};
    assign y_dut[2] = {3'b000, if2.y};
    assign y_dut[3] = {3'b000, if3.y};
    assign y_dut[4] = if4.y;
    assign g_dut[0] = {2'b00, if0.glitch};
    assign g_dut[1] = {3'b000, if1.glitch};
    assign g_dut[2] = {3'b000, if2.glitch};
    assign g_dut[3] = {3'b000, if3.glitch};
    assign g_dut[4] = if4.glitch;

    initial SIM_CLK = 1'b0;
    always #5 SIM_CLK = ~SIM_CLK;

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // Model state: newest-first history of negedge samples since the last reset.
    logic [63:0] sh_m  [NK][4];
    int          len_m [NK][4];
    logic        y_m   [NK][4];
    logic        g_m   [NK][4];
    logic        smp   [NK][4];
    bit          model_ok = 1'b0;

    always @(negedge SIM_CLK) begin
        for (int k = 0; k < NK; k++) begin
            for (int c = 0; c < P_CH[k]; c++) begin
                logic rv;
                rv = 1'b1;
                for (int i = 0; i < P_N[k]; i++) begin
                    if (a_drv[k][c*P_N[k] + i]) rv = 1'b0;
                end
                smp[k][c] = rv;
            end
        end
    end

    task automatic model_update();
        for (int k = 0; k < NK; k++) begin
            for (int c = 0; c < P_CH[k]; c++) begin
                logic ivb;
                int   run;
                ivb = 1'((P_IV[k] >> c) & 1);
                if (!SIM_RST) begin
                    y_m[k][c]   = ivb;
                    g_m[k][c]   = 1'b0;
                    len_m[k][c] = 0;
                    sh_m[k][c]  = {64{ivb}};
                    model_ok    = 1'b1;
                end else begin
                    sh_m[k][c] = {sh_m[k][c][62:0], smp[k][c]};
                    if (len_m[k][c] < 64) len_m[k][c]++;
                    if (P_MODE[k] == 1) begin
                        // Pure delay: the sample from DELAY posedges back.
                        y_m[k][c] = sh_m[k][c][P_D[k]-1];
                        g_m[k][c] = 1'b0;
                    end else begin
                        run = 0;
                        while (run < len_m[k][c] && sh_m[k][c][run] != y_m[k][c]) run++;
                        if (run >= P_D[k]) begin
                            y_m[k][c] = sh_m[k][c][0];
                            g_m[k][c] = 1'b0;
                        end else begin
                            g_m[k][c] = (sh_m[k][c][0] == y_m[k][c]) && (len_m[k][c] >= 2)
                                        && (sh_m[k][c][1] != y_m[k][c]);
                        end
                    end
                end
            end
        end
    endtask

    always begin
        @(posedge SIM_CLK);
        model_update();
        #1;
        if (model_ok) begin
            for (int k = 0; k < NK; k++) begin
                for (int c = 0; c < P_CH[k]; c++) begin
                    chk($sformatf("model_y k%0d c%0d", k, c), {3'b000, y_dut[k][c]}, {3'b000, y_m[k][c]});
                    chk($sformatf("model_glitch k%0d c%0d", k, c), {3'b000, g_dut[k][c]}, {3'b000, g_m[k][c]});
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge SIM_CLK);
        #1;
    endtask

    logic want [NK][4];

    initial begin
        checks   = 0;
        failures = 0;
        SIM_RST  = 1'b0;
        for (int k = 0; k < NK; k++) a_drv[k] = '0;

        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("reset_y", y_dut[0], 4'b0001);
            chk("reset_glitch", g_dut[0], 4'b0000);
        end

        SIM_RST = 1'b1;
        step(1);
        chk("delay1_rise", y_dut[0], 4'b0011);
        step(3);

        a_drv[1] = 8'h01;
        step(2);
        chk("inert_short_hold", y_dut[1], 4'b0001);
        a_drv[1] = 8'h00;
        step(1);
        chk("inert_short_glitch", g_dut[1], 4'b0001);
        chk("inert_short_y", y_dut[1], 4'b0001);
        step(1);
        chk("inert_glitch_one_cycle", g_dut[1], 4'b0000);
        step(2);

        a_drv[1] = 8'h04;
        step(2);
        chk("inert_long_wait", y_dut[1], 4'b0001);
        step(1);
        chk("inert_long_fall", y_dut[1], 4'b0000);
        chk("inert_long_noglitch", g_dut[1], 4'b0000);
        a_drv[1] = 8'h00;
        step(3);
        chk("inert_long_rise", y_dut[1], 4'b0001);

        a_drv[2] = 8'h02;
        step(1);
        a_drv[2] = 8'h00;
        step(1);
        chk("transport_before", y_dut[2], 4'b0001);
        step(1);
        chk("transport_pulse", y_dut[2], 4'b0000);
        chk("transport_glitch", g_dut[2], 4'b0000);
        step(1);
        chk("transport_after", y_dut[2], 4'b0001);

        a_drv[3] = 8'h08;
        step(2);
        SIM_RST = 1'b0;
        step(1);
        chk("reset_pending_y", y_dut[3], 4'b0001);
        chk("reset_pending_glitch", g_dut[3], 4'b0000);
        SIM_RST = 1'b1;
        step(3);
        chk("reset_discards_pending", y_dut[3], 4'b0001);
        step(1);
        chk("fresh_four_samples", y_dut[3], 4'b0000);
        a_drv[3] = 8'h00;

        a_drv[4] = 8'b11_10_01_00;
        step(1);
        chk("bank_first_sample", y_dut[4], 4'b1111);
        step(1);
        chk("bank_patterns", y_dut[4], 4'b0001);
        a_drv[4] = 8'h00;
        step(2);

        for (int k = 0; k < NK; k++)
            for (int c = 0; c < 4; c++) want[k][c] = 1'b1;

        for (int n = 0; n < 800; n++) begin
            SIM_RST = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
            for (int k = 0; k < NK; k++) begin
                for (int c = 0; c < P_CH[k]; c++) begin
                    if ($urandom_range(0, 2) == 0) want[k][c] = ~want[k][c];
                    for (int i = 0; i < P_N[k]; i++) a_drv[k][c*P_N[k] + i] = 1'b0;
                    if (!want[k][c]) begin
                        for (int i = 0; i < P_N[k]; i++) a_drv[k][c*P_N[k] + i] = 1'($urandom_range(0, 1));
                        a_drv[k][c*P_N[k] + $urandom_range(0, P_N[k] - 1)] = 1'b1;
                    end
                end
            end
            step(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
